// File: rtl/disp_scan_if.sv
// Display-scanner bus: CPU port values and controls in, multiplexed
// seven-segment drive and frame strobe out.
interface disp_scan_if;
  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s3;
  logic [7:0] s4;
  logic       en;
  logic       hold;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  // Side that supplies values and controls and watches the display.
  modport master (
    output s1, s2, s3, s4, en, hold,
    input  an, seg, dp, frame
  );

  // The scanner itself.
  modport slave (
    input  s1, s2, s3, s4, en, hold,
    output an, seg, dp, frame
  );
endinterface

// File: rtl/disp_scan.sv
// disp_scan: eight-digit multiplexed seven-segment scanner. Each digit
// gets one slot of TICK_DIV clocks. The first BLANK clocks of a slot keep
// all anodes off so segment changes never ghost onto a neighbouring digit.
// The four 8-bit values are sampled once per frame (at the end of digit 7)
// so every frame shows one coherent snapshot.

// Display invariants: never more than one anode active, and a dark display
// always has segments and decimal point off.
module disp_scan_chk (
  input logic       clk,
  input logic       reset,
  input logic [7:0] an,
  input logic [6:0] seg,
  input logic       dp
);
  a_one_anode : assert property (@(posedge clk) disable iff (reset)
    $onehot0(~an));

  a_dark_blank : assert property (@(posedge clk) disable iff (reset)
    (an == 8'hFF) |-> ((seg == 7'h7F) && dp));
endmodule

module disp_scan #(
  parameter int TICK_DIV = 50000,
  parameter int BLANK    = 16
) (
  input logic         clk,
  input logic         reset,
  disp_scan_if.slave  bus
);

  localparam int             CW         = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  TICK_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  BLANK_INIT = CW'(BLANK);

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // State
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    idx_q,      idx_d;
  logic [CW-1:0] blank_q,    blank_d;
  logic [31:0]   snap_q,     snap_d;     // {s1, s2, s3, s4}
  logic          frame_q,    frame_d;
  logic [7:0]    an_q,       an_d;
  logic [6:0]    seg_q,      seg_d;
  logic          dp_q,       dp_d;

  // Combinational helpers
  logic          tick_s;
  logic          load_s;
  logic          dark_s;
  logic [3:0]    nib_s;

  // Last clock of a digit slot.
  assign tick_s = (tick_cnt_q == TICK_MAX);

  // Snapshot reloads only at the end of digit 7, and only when not frozen.
  assign load_s = tick_s && (idx_q == 3'd7) && !bus.hold;

  // Slot timing: tick counter, digit index and the blanking countdown.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    idx_d      = idx_q;
    blank_d    = blank_q;
    if (tick_s) begin
      tick_cnt_d = CW'(0);
      idx_d      = idx_q + 3'd1;
      blank_d    = BLANK_INIT;
    end else begin
      tick_cnt_d = tick_cnt_q + CW'(1);
      idx_d      = idx_q;
      if (blank_q != CW'(0)) begin
        blank_d = blank_q - CW'(1);
      end else begin
        blank_d = blank_q;
      end
    end
  end

  // Snapshot capture and the frame strobe that marks it.
  always_comb begin
    snap_d  = snap_q;
    frame_d = 1'b0;
    if (load_s) begin
      snap_d  = {bus.s1, bus.s2, bus.s3, bus.s4};
      frame_d = 1'b1;
    end else begin
      snap_d  = snap_q;
      frame_d = 1'b0;
    end
  end

  // Select the nibble for the current digit: 7/6 = s1, ..., 1/0 = s4.
  always_comb begin
    nib_s = 4'h0;
    case (idx_q)
      3'd7:    nib_s = snap_q[31:28];
      3'd6:    nib_s = snap_q[27:24];
      3'd5:    nib_s = snap_q[23:20];
      3'd4:    nib_s = snap_q[19:16];
      3'd3:    nib_s = snap_q[15:12];
      3'd2:    nib_s = snap_q[11:8];
      3'd1:    nib_s = snap_q[7:4];
      3'd0:    nib_s = snap_q[3:0];
      default: nib_s = 4'h0;
    endcase
  end

  // Next anode/segment/dp drive; dark during blanking or when disabled.
  always_comb begin
    dark_s = (blank_q != CW'(0)) || !bus.en;
    an_d   = 8'hFF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (dark_s) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = hex_to_seg(nib_s);
      if ((idx_q == 3'd6) || (idx_q == 3'd4) || (idx_q == 3'd2)) begin
        dp_d = 1'b0;
      end else begin
        dp_d = 1'b1;
      end
    end
  end

  // State and output registers; reset wins over tick, hold and load.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= CW'(0);
      idx_q      <= 3'd0;
      blank_q    <= BLANK_INIT;
      snap_q     <= 32'h0000_0000;
      frame_q    <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      blank_q    <= blank_d;
      snap_q     <= snap_d;
      frame_q    <= frame_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

  disp_scan_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .an    (an_q),
    .seg   (seg_q),
    .dp    (dp_q)
  );

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter TICK_DIV, default 50000, clocks per digit slot; legal range >= 2.
REQ-002 Parameter BLANK, default 16, all-anodes-off cycles at the start of each slot; legal range 0 to TICK_DIV-1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s1, s2, s3, s4  input  8 each  CPU output-port values to display.
REQ-006 en  input  1  display enable; 0 forces the display dark.
REQ-007 hold  input  1  1 freezes the displayed snapshot.
REQ-008 an  output  8  digit anodes, active-low, bit k = digit k.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low.
REQ-011 frame  output  1  one-cycle pulse when the snapshot loads.

Function
REQ-012 Tick counter shall count 0..TICK_DIV-1 and wrap to 0; tick is true in the cycle it holds TICK_DIV-1.
REQ-013 Digit index idx (3 bits) shall increment on tick, wrapping 7->0.
REQ-014 Blank counter shall load BLANK on tick, else decrement while nonzero, and hold at 0.
REQ-015 On a tick where idx is 7 and hold=0, snapshot registers shall load s1..s4 as sampled in that cycle; frame shall be 1 in the following cycle only.
REQ-016 With hold=1 the snapshot shall not load and frame shall stay 0; idx, tick and blank counters shall keep running.
REQ-017 Digit map: digit 7/6 = snapshot s1 high/low nibble; 5/4 = s2; 3/2 = s3; 1/0 = s4.
REQ-018 Hex encoding (active-low seg): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 dp shall be 0 when the displayed digit is 6, 4 or 2, otherwise 1.
REQ-020 an, seg and dp shall be registered outputs; in cycle n+1 they reflect idx, blank counter, snapshot and en from cycle n.
REQ-021 an shall be 8'hFF when blank counter is nonzero or en=0; otherwise an shall be all ones except bit idx = 0.
REQ-022 When an=8'hFF, seg shall be 7'h7F and dp shall be 1.
REQ-023 At most one an bit shall be 0 in any cycle.
REQ-024 Changes on s1..s4 between snapshot loads shall not affect an, seg or dp.
REQ-025 Toggling en shall not disturb the counters or the snapshot.

Reset
REQ-026 While reset=1 at a clock edge: tick counter=0, idx=0, blank counter=BLANK, snapshot=0, an=8'hFF, seg=7'h7F, dp=1, frame=0.
REQ-027 After reset release, digit 0 shall light (an=8'hFE, seg=1000000) in the cycle after the blank counter reaches 0.
REQ-028 Reset asserted mid-slot or mid-blank shall take effect at the next edge, overriding tick, hold and snapshot load.

Verification (TICK_DIV=4, BLANK=1)
REQ-029 Reset, en=1, s1..s4=0 -> an=FF for 2 cycles, then FE with seg=1000000 and dp=1; an=FD after 4 more cycles, preceded by 1 cycle of FF.
REQ-030 s1=8'hA5, s2=8'h3C, s3=8'h0F, s4=8'h81, hold=0, run one full frame -> frame pulses once; next frame digits 7..0 show A,5,3,C,0,F,8,1; dp=0 on digits 6, 4 and 2 only.
REQ-031 After the snapshot of REQ-030, set hold=1 and change s1 to 8'h00 -> digits 7/6 still show A/5 over 3 frames, frame stays 0; release hold -> shows 0/0 after the next load.
REQ-032 en=0 for 10 cycles mid-slot -> an=FF, seg=7F, dp=1 throughout; on re-enable the lit digit equals the idx it would have reached with en=1.
REQ-033 Assert reset while digit 5 is lit -> next cycle an=FF, seg=7F, frame=0; snapshot reads 0 on subsequent digits.
REQ-034 Over any run, check every cycle that an has at most one 0 bit and that s1..s4 changes show only after a frame pulse.
